pe_wrapper_buffered: RTL and testbench
======================================

Name: pe_wrapper_buffered

Overview:
Next-generation PE wrapper between the GLB/NoC-side {enable,data} bundled ports and a PE core. It adds per-channel input FIFOs, a buffered opsum output FIFO, and addressed config latching with drain-before-apply. It also adds a bypass mode that forwards ipsum straight to opsum, and a saturating output counter. One instance sits at each PE array slot (MA_X, MA_Y).

Parameters:
IFMAP_DATA_SIZE, 8, bits per ifmap word
FILTER_DATA_SIZE, 8, bits per filter word
PSUM_DATA_SIZE, 8, bits per psum word
IFMAP_NUM / FILTER_NUM / IPSUM_NUM / OPSUM_NUM, 1 / 4 / 1 / 1, words per transfer per channel; IPSUM_NUM must equal OPSUM_NUM
FIFO_DEPTH, 4, entries per FIFO; power of two, at least 2
CFG_PAYLOAD_BIT, 39, width of the core config payload (q2+p5+U4+S4+F12+W12)
ID_BIT, 5, width of each of the X and Y tag fields
MA_X, 0, column ID of this PE
MA_Y, 0, row ID of this PE

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
enable  in  1  global enable
ifmap_in  in  IFMAP_NUM*IFMAP_DATA_SIZE+1  MSB = enable, rest = data
ifmap_ready  out  1  ifmap FIFO can accept
filter_in  in  FILTER_NUM*FILTER_DATA_SIZE+1  MSB = enable, rest = data
filter_ready  out  1  filter FIFO can accept
ipsum_in  in  IPSUM_NUM*PSUM_DATA_SIZE+1  MSB = enable, rest = data
ipsum_ready  out  1  ipsum FIFO can accept
opsum_out  out  OPSUM_NUM*PSUM_DATA_SIZE+1  MSB = valid, rest = data
opsum_ready  in  1  downstream accepts opsum
config_in  in  1+1+2*ID_BIT+CFG_PAYLOAD_BIT  {set_info, mode, tag_y, tag_x, payload}
cfg_busy  out  1  a config is pending (draining)
core_ifmap / core_filter / core_ipsum  out  channel data width  FIFO heads
core_ifmap_valid / core_filter_valid / core_ipsum_valid  out  1  head valid to core
core_ifmap_ready / core_filter_ready / core_ipsum_ready  in  1  core pops head
core_opsum  in  OPSUM_NUM*PSUM_DATA_SIZE  core result
core_opsum_valid  in  1  core result valid
core_opsum_ready  out  1  output FIFO can accept core result
cfg_payload  out  CFG_PAYLOAD_BIT  active config to core
cfg_load  out  1  one-cycle pulse when cfg_payload updates
cfg_mode  out  1  active mode: 0 compute, 1 bypass
opsum_count  out  16  outputs emitted since last cfg_load, saturating

Behaviour:
- Reset: rst is asynchronous and active-low; rst=0 clears everything.
  - All FIFOs empty; every *_ready and *_valid output is 0.
  - opsum_out = 0; cfg_payload = 0, cfg_mode = 0, cfg_load = 0, cfg_busy = 0, opsum_count = 0.
  - Reset mid-transfer discards all buffered data.
- Transfers: an input transfer occurs when enable bit = 1 and the matching ready = 1 in the same cycle. Core-side transfers occur on valid && ready.
- FIFOs are registered, not fall-through:
  - A pushed word is visible at the head the next cycle.
  - ready = !full. A push while full is never accepted, even with a simultaneous pop.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Channel readies: ifmap_ready / filter_ready / ipsum_ready = !full && enable && !cfg_busy.
  - In bypass mode, ifmap_ready and filter_ready are forced to 0.
- enable = 0:
  - Input readies and core valids are 0, and core_opsum_ready = 0.
  - The output FIFO still drains to opsum_out.
- Compute mode: core_X_valid = !empty_X && enable; core_opsum_ready = !out_full && enable. A core result pushes into the output FIFO.
- Bypass mode:
  - Core valids = 0 and core_opsum_ready = 0.
  - Each cycle with ipsum non-empty, output not full and enable = 1, the ipsum head moves to the output FIFO. Throughput is 1 per cycle; latency from ipsum_in accepted to opsum_out valid is 2 cycles.
- Output: opsum_out = {!out_empty, head}; data = 0 when empty. A pop occurs when valid && opsum_ready. Head and valid are held stable while opsum_ready = 0.
- opsum_count increments on each output pop and saturates at 16'hFFFF.
- Config accept: config_in is accepted when set_info = 1 and either (tag_x == MA_X and tag_y == MA_Y), or tag_x and tag_y are all-ones (broadcast). Non-matching commands are ignored.
- Config FSM, states IDLE / PENDING / APPLY:
  - IDLE, accept: capture {mode, payload} into a shadow register and go to PENDING.
  - PENDING: cfg_busy = 1. Stay until all four FIFOs are empty and no core transfer occurs in the current cycle, then go to APPLY.
  - PENDING, new accepted command: overwrites the shadow register (last wins).
  - APPLY: cfg_payload and cfg_mode take the shadow values, cfg_load = 1 for one cycle, opsum_count clears, cfg_busy = 0, then return to IDLE.
  - Accept with everything already empty: PENDING lasts exactly 1 cycle, so cfg_load rises 2 cycles after the set_info cycle.
  - cfg_busy = 0 in IDLE and APPLY. An accepted command in APPLY captures into the shadow register and returns to PENDING.

Test Plan:
- Reset, then one ifmap push of 8'h5A with core_ifmap_ready = 0 -> core_ifmap_valid = 1 next cycle with data 5A; value held until core_ifmap_ready = 1, then valid = 0.
- Push 5 filter words at FIFO_DEPTH = 4 with core stalled -> filter_ready drops after 4 accepts, the 5th word is not accepted, and the FIFO count stays 4.
- Core emits 3 results with opsum_ready = 0 -> opsum_out valid with the first result stable throughout; on release, 3 pops occur in order and opsum_count = 3.
- Broadcast config (tags all-ones, mode = 1, payload = 39'h12345) while 2 ifmap words are buffered -> cfg_busy = 1 and input readies = 0 until the core pops both words; cfg_load pulses once, cfg_mode = 1, cfg_payload = 12345, and opsum_count resets to 0.
- Bypass mode, ipsum stream 1,2,3 with opsum_ready = 1 -> opsum_out shows 1,2,3 each 2 cycles after acceptance; core_ipsum_valid stays 0.
- Config with tag_x = MA_X+1 -> ignored (no cfg_busy); rst = 0 asserted mid-stream -> all outputs 0 asynchronously and FIFOs empty after release.

Source files
------------

// File: rtl/pe_wrapper_buffered.sv
// PE-slot wrapper: per-channel input FIFOs, buffered opsum output, addressed
// config with drain-before-apply, ipsum bypass mode and a saturating output count.

module pe_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [NW-1:0] count;
  logic          push_ok, pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop_ok) rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module pe_wrapper_buffered #(
  parameter int IFMAP_DATA_SIZE  = 8,
  parameter int FILTER_DATA_SIZE = 8,
  parameter int PSUM_DATA_SIZE   = 8,
  parameter int IFMAP_NUM        = 1,
  parameter int FILTER_NUM       = 4,
  parameter int IPSUM_NUM        = 1,
  parameter int OPSUM_NUM        = 1,
  parameter int FIFO_DEPTH       = 4,
  parameter int CFG_PAYLOAD_BIT  = 39,
  parameter int ID_BIT           = 5,
  parameter int MA_X             = 0,
  parameter int MA_Y             = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      enable,
  input  logic [IFMAP_NUM*IFMAP_DATA_SIZE:0]        ifmap_in,
  output logic                                      ifmap_ready,
  input  logic [FILTER_NUM*FILTER_DATA_SIZE:0]      filter_in,
  output logic                                      filter_ready,
  input  logic [IPSUM_NUM*PSUM_DATA_SIZE:0]         ipsum_in,
  output logic                                      ipsum_ready,
  output logic [OPSUM_NUM*PSUM_DATA_SIZE:0]         opsum_out,
  input  logic                                      opsum_ready,
  input  logic [1+1+2*ID_BIT+CFG_PAYLOAD_BIT-1:0]   config_in,
  output logic                                      cfg_busy,
  output logic [IFMAP_NUM*IFMAP_DATA_SIZE-1:0]      core_ifmap,
  output logic [FILTER_NUM*FILTER_DATA_SIZE-1:0]    core_filter,
  output logic [IPSUM_NUM*PSUM_DATA_SIZE-1:0]       core_ipsum,
  output logic                                      core_ifmap_valid,
  output logic                                      core_filter_valid,
  output logic                                      core_ipsum_valid,
  input  logic                                      core_ifmap_ready,
  input  logic                                      core_filter_ready,
  input  logic                                      core_ipsum_ready,
  input  logic [OPSUM_NUM*PSUM_DATA_SIZE-1:0]       core_opsum,
  input  logic                                      core_opsum_valid,
  output logic                                      core_opsum_ready,
  output logic [CFG_PAYLOAD_BIT-1:0]                cfg_payload,
  output logic                                      cfg_load,
  output logic                                      cfg_mode,
  output logic [15:0]                               opsum_count,
  output logic [1:0]                                cfg_state
);
  // Handshake: every transfer happens on a cycle where valid (or the MSB enable
  // bit) and ready are both 1; ready never depends on the matching valid.
  localparam int IW = IFMAP_NUM * IFMAP_DATA_SIZE;
  localparam int FW = FILTER_NUM * FILTER_DATA_SIZE;
  localparam int PW = IPSUM_NUM * PSUM_DATA_SIZE;
  localparam int OW = OPSUM_NUM * PSUM_DATA_SIZE;
  localparam int CW = 2 + 2 * ID_BIT + CFG_PAYLOAD_BIT;
  localparam logic [ID_BIT-1:0] MY_X = ID_BIT'(MA_X);
  localparam logic [ID_BIT-1:0] MY_Y = ID_BIT'(MA_Y);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] APPLY   = 2'd2;

  logic          run, in_ok;
  logic          if_full, if_empty, fl_full, fl_empty, ip_full, ip_empty, out_full, out_empty;
  logic [IW-1:0] if_head;
  logic [FW-1:0] fl_head;
  logic [PW-1:0] ip_head;
  logic [OW-1:0] out_head, out_data;
  logic          if_push, fl_push, ip_push, out_push;
  logic          if_pop, fl_pop, ip_pop, out_pop;
  logic          bypass_move, core_res_fire, drained;

  logic                       cfg_set, cfg_mode_in, accept, apply_now;
  logic [ID_BIT-1:0]          tag_x, tag_y;
  logic [CFG_PAYLOAD_BIT-1:0] payload_in, shadow_payload;
  logic                       shadow_mode;
  logic [1:0]                 state;

  // Reset also gates the combinational readies so everything reads 0 while rst is low.
  assign run   = enable && rst;
  assign in_ok = run && !cfg_busy;

  assign ifmap_ready  = !if_full && in_ok && !cfg_mode;
  assign filter_ready = !fl_full && in_ok && !cfg_mode;
  assign ipsum_ready  = !ip_full && in_ok;
  assign if_push      = ifmap_in[IW] && ifmap_ready;
  assign fl_push      = filter_in[FW] && filter_ready;
  assign ip_push      = ipsum_in[PW] && ipsum_ready;

  assign core_ifmap        = if_head;
  assign core_filter       = fl_head;
  assign core_ipsum        = ip_head;
  assign core_ifmap_valid  = !if_empty && run && !cfg_mode;
  assign core_filter_valid = !fl_empty && run && !cfg_mode;
  assign core_ipsum_valid  = !ip_empty && run && !cfg_mode;
  assign core_opsum_ready  = !out_full && run && !cfg_mode;

  assign bypass_move   = cfg_mode && run && !ip_empty && !out_full;
  assign core_res_fire = core_opsum_valid && core_opsum_ready;
  assign if_pop        = core_ifmap_valid && core_ifmap_ready;
  assign fl_pop        = core_filter_valid && core_filter_ready;
  assign ip_pop        = cfg_mode ? bypass_move : (core_ipsum_valid && core_ipsum_ready);
  assign out_push      = cfg_mode ? bypass_move : core_res_fire;
  assign out_data      = cfg_mode ? OW'(ip_head) : core_opsum;
  assign out_pop       = !out_empty && opsum_ready;
  assign opsum_out     = {!out_empty, out_empty ? {OW{1'b0}} : out_head};

  pe_fifo #(.W(IW), .DEPTH(FIFO_DEPTH)) u_ifmap_fifo (
    .clk(clk), .rst(rst), .push(if_push), .push_data(ifmap_in[IW-1:0]),
    .pop(if_pop), .head(if_head), .full(if_full), .empty(if_empty));
  pe_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_filter_fifo (
    .clk(clk), .rst(rst), .push(fl_push), .push_data(filter_in[FW-1:0]),
    .pop(fl_pop), .head(fl_head), .full(fl_full), .empty(fl_empty));
  pe_fifo #(.W(PW), .DEPTH(FIFO_DEPTH)) u_ipsum_fifo (
    .clk(clk), .rst(rst), .push(ip_push), .push_data(ipsum_in[PW-1:0]),
    .pop(ip_pop), .head(ip_head), .full(ip_full), .empty(ip_empty));
  pe_fifo #(.W(OW), .DEPTH(FIFO_DEPTH)) u_opsum_fifo (
    .clk(clk), .rst(rst), .push(out_push), .push_data(out_data),
    .pop(out_pop), .head(out_head), .full(out_full), .empty(out_empty));

  assign cfg_set     = config_in[CW-1];
  assign cfg_mode_in = config_in[CW-2];
  assign tag_y       = config_in[CFG_PAYLOAD_BIT+2*ID_BIT-1 -: ID_BIT];
  assign tag_x       = config_in[CFG_PAYLOAD_BIT+ID_BIT-1 -: ID_BIT];
  assign payload_in  = config_in[CFG_PAYLOAD_BIT-1:0];
  assign accept      = cfg_set && (((tag_x == MY_X) && (tag_y == MY_Y)) || ((&tag_x) && (&tag_y)));

  // With every FIFO empty the only possible core transfer is a result push.
  assign drained   = if_empty && fl_empty && ip_empty && out_empty && !core_res_fire && !bypass_move;
  assign apply_now = (state == PENDING) && !accept && drained;
  assign cfg_busy  = (state == PENDING);
  assign cfg_load  = (state == APPLY);
  assign cfg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      shadow_payload <= '0;
      shadow_mode    <= 1'b0;
      cfg_payload    <= '0;
      cfg_mode       <= 1'b0;
    end else begin
      if (accept) begin
        shadow_payload <= payload_in;
        shadow_mode    <= cfg_mode_in;
      end
      case (state)
        IDLE:    if (accept) state <= PENDING;
        PENDING: if (apply_now) begin
          state       <= APPLY;
          cfg_payload <= shadow_payload;
          cfg_mode    <= shadow_mode;
        end
        APPLY:   state <= accept ? PENDING : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) opsum_count <= '0;
    else if (apply_now) opsum_count <= '0;
    else if (out_pop && (opsum_count != 16'hFFFF)) opsum_count <= opsum_count + 16'd1;
  end
endmodule

// File: tb/tb_pe_wrapper_buffered.sv
// Bench for pe_wrapper_buffered: config-decode vector table, hand-written
// multi-cycle sequences, and an opsum scoreboard fed from the stimulus side.

module tb_pe_wrapper_buffered;
  logic        clk = 1'b0;
  logic        rst, enable;
  logic [8:0]  ifmap_in, ipsum_in, opsum_out;
  logic [32:0] filter_in;
  logic        ifmap_ready, filter_ready, ipsum_ready, opsum_ready;
  logic [50:0] config_in;
  logic        cfg_busy, cfg_load, cfg_mode;
  logic [7:0]  core_ifmap, core_ipsum, core_opsum;
  logic [31:0] core_filter;
  logic        core_ifmap_valid, core_filter_valid, core_ipsum_valid;
  logic        core_ifmap_ready, core_filter_ready, core_ipsum_ready;
  logic        core_opsum_valid, core_opsum_ready;
  logic [38:0] cfg_payload;
  logic [15:0] opsum_count;
  logic [1:0]  cfg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       set;
    logic [4:0] tx;
    logic [4:0] ty;
    logic       exp_busy;
  } cfg_vec_t;
  cfg_vec_t vecs[6];

  pe_wrapper_buffered dut (
    .clk(clk), .rst(rst), .enable(enable),
    .ifmap_in(ifmap_in), .ifmap_ready(ifmap_ready),
    .filter_in(filter_in), .filter_ready(filter_ready),
    .ipsum_in(ipsum_in), .ipsum_ready(ipsum_ready),
    .opsum_out(opsum_out), .opsum_ready(opsum_ready),
    .config_in(config_in), .cfg_busy(cfg_busy),
    .core_ifmap(core_ifmap), .core_filter(core_filter), .core_ipsum(core_ipsum),
    .core_ifmap_valid(core_ifmap_valid), .core_filter_valid(core_filter_valid),
    .core_ipsum_valid(core_ipsum_valid),
    .core_ifmap_ready(core_ifmap_ready), .core_filter_ready(core_filter_ready),
    .core_ipsum_ready(core_ipsum_ready),
    .core_opsum(core_opsum), .core_opsum_valid(core_opsum_valid),
    .core_opsum_ready(core_opsum_ready),
    .cfg_payload(cfg_payload), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
    .opsum_count(opsum_count), .cfg_state(cfg_state));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [50:0] cfg_cmd(input logic set, input logic mode,
                                          input logic [4:0] ty, input logic [4:0] tx,
                                          input logic [38:0] pl);
    return {set, mode, ty, tx, pl};
  endfunction

  // Scoreboard: compare every opsum pop against the expected queue.
  always @(negedge clk) begin
    if (rst && opsum_out[8] && opsum_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL opsum_unexpected: got %0h expected none", opsum_out[7:0]);
      end else begin
        chk("opsum_data", opsum_out[7:0], exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int loads;
    logic [7:0] res [3];
    vecs[0] = '{1'b1, 5'd0,  5'd0,  1'b1};
    vecs[1] = '{1'b1, 5'd1,  5'd0,  1'b0};
    vecs[2] = '{1'b1, 5'd0,  5'd1,  1'b0};
    vecs[3] = '{1'b1, 5'd31, 5'd31, 1'b1};
    vecs[4] = '{1'b0, 5'd0,  5'd0,  1'b0};
    vecs[5] = '{1'b1, 5'd31, 5'd0,  1'b0};
    res[0] = 8'h11; res[1] = 8'h22; res[2] = 8'h33;

    rst = 1'b0; enable = 1'b1;
    ifmap_in = '0; filter_in = '0; ipsum_in = '0; config_in = '0;
    opsum_ready = 1'b0; core_opsum = '0; core_opsum_valid = 1'b0;
    core_ifmap_ready = 1'b0; core_filter_ready = 1'b0; core_ipsum_ready = 1'b0;
    #3;
    chk("rst_opsum_out", opsum_out, 9'h0);
    chk("rst_readies", {ifmap_ready, filter_ready, ipsum_ready, core_opsum_ready}, 4'h0);
    chk("rst_valids", {core_ifmap_valid, core_filter_valid, core_ipsum_valid}, 3'h0);
    chk("rst_cfg", {cfg_busy, cfg_load, cfg_mode, cfg_state}, 5'h0);
    chk("rst_payload", cfg_payload, 39'h0);
    chk("rst_count", opsum_count, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick;
    chk("idle_readies", {ifmap_ready, filter_ready, ipsum_ready, core_opsum_ready}, 4'hF);

    // Config address decode table (mode 0 payloads).
    for (int i = 0; i < 6; i++) begin
      config_in = cfg_cmd(vecs[i].set, 1'b0, vecs[i].ty, vecs[i].tx, 39'(100 + i));
      tick;
      config_in = '0;
      #1;
      chk("cfg_busy_decode", cfg_busy, vecs[i].exp_busy);
      tick;
      chk("cfg_load_decode", cfg_load, vecs[i].exp_busy);
      if (vecs[i].exp_busy) chk("cfg_payload_decode", cfg_payload, 39'(100 + i));
      tick;
    end

    // Single ifmap word held at head while the core stalls.
    ifmap_in = {1'b1, 8'h5A};
    #1 chk("ifmap_not_fallthrough", core_ifmap_valid, 1'b0);
    tick;
    ifmap_in = '0;
    #1 chk("ifmap_head", {core_ifmap_valid, core_ifmap}, {1'b1, 8'h5A});
    tick;
    chk("ifmap_held", {core_ifmap_valid, core_ifmap}, {1'b1, 8'h5A});
    core_ifmap_ready = 1'b1;
    tick;
    core_ifmap_ready = 1'b0;
    #1 chk("ifmap_popped", core_ifmap_valid, 1'b0);

    // Filter FIFO overflow: fifth word must be refused.
    for (int i = 0; i < 5; i++) begin
      filter_in = {1'b1, 32'hF000_0000 + 32'(i)};
      #1 chk("filter_ready_fill", filter_ready, (i < 4));
      tick;
    end
    filter_in = '0;
    core_filter_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("filter_drain", {core_filter_valid, core_filter}, {1'b1, 32'hF000_0000 + 32'(i)});
      tick;
    end
    #1 chk("filter_empty", core_filter_valid, 1'b0);
    core_filter_ready = 1'b0;

    // Core results buffered behind a stalled downstream.
    for (int i = 0; i < 3; i++) begin
      core_opsum = res[i];
      core_opsum_valid = 1'b1;
      #1 chk("core_opsum_ready", core_opsum_ready, 1'b1);
      if (core_opsum_ready) exp_q.push_back(res[i]);
      tick;
    end
    core_opsum_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("opsum_stall_hold", opsum_out, {1'b1, 8'h11});
      tick;
    end
    opsum_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick;
      n++;
    end
    chk("opsum_drain_timeout", (n < 20), 1'b1);
    #1 chk("opsum_count_3", opsum_count, 16'd3);
    chk("opsum_empty_after", opsum_out, 9'h0);

    // Broadcast config to bypass while two ifmap words are buffered.
    ifmap_in = {1'b1, 8'hA1};
    tick;
    ifmap_in = {1'b1, 8'hA2};
    tick;
    ifmap_in = '0;
    config_in = cfg_cmd(1'b1, 1'b1, 5'h1F, 5'h1F, 39'h12345);
    tick;
    config_in = '0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("pending_busy", {cfg_busy, ifmap_ready, filter_ready, ipsum_ready}, 4'b1000);
      tick;
    end
    core_ifmap_ready = 1'b1;
    #1 chk("pending_pop1", {cfg_busy, core_ifmap}, {1'b1, 8'hA1});
    tick;
    chk("pending_pop2", {cfg_busy, core_ifmap}, {1'b1, 8'hA2});
    tick;
    core_ifmap_ready = 1'b0;
    loads = 0;
    for (int k = 0; k < 6; k++) begin
      if (cfg_load) loads++;
      tick;
    end
    chk("cfg_load_once", loads, 1);
    chk("cfg_mode_bypass", cfg_mode, 1'b1);
    chk("cfg_payload_bcast", cfg_payload, 39'h12345);
    chk("count_cleared", opsum_count, 16'd0);
    chk("busy_released", cfg_busy, 1'b0);

    // Bypass stream 1,2,3: each appears two cycles after acceptance.
    for (int j = 0; j < 5; j++) begin
      ipsum_in = (j < 3) ? {1'b1, 8'(j + 1)} : 9'h0;
      #1;
      if (j < 3) begin
        chk("bypass_ipsum_ready", ipsum_ready, 1'b1);
        exp_q.push_back(8'(j + 1));
      end
      chk("bypass_core_valid", {core_ipsum_valid, ifmap_ready, filter_ready}, 3'b000);
      if (j >= 2) chk("bypass_out", opsum_out, {1'b1, 8'(j - 1)});
      tick;
    end
    chk("bypass_done", opsum_out, 9'h0);
    chk("bypass_count", opsum_count, 16'd3);

    // Asynchronous reset in the middle of a bypass stream.
    ipsum_in = {1'b1, 8'h07};
    tick;
    ipsum_in = {1'b1, 8'h08};
    tick;
    ipsum_in = '0;
    opsum_ready = 1'b0;
    #1 chk("pre_reset_out", opsum_out, {1'b1, 8'h07});
    #1 rst = 1'b0;
    #1;
    chk("async_rst_out", opsum_out, 9'h0);
    chk("async_rst_ready", {ipsum_ready, core_opsum_ready}, 2'b00);
    chk("async_rst_cfg", {cfg_mode, cfg_busy, cfg_state}, 4'h0);
    chk("async_rst_payload", cfg_payload, 39'h0);
    chk("async_rst_count", opsum_count, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    tick;
    chk("post_rst_empty", {opsum_out[8], core_ipsum_valid, core_ifmap_valid}, 3'b000);
    chk("post_rst_ready", {ipsum_ready, ifmap_ready, core_opsum_ready}, 3'b111);
    tick;
    chk("post_rst_still_empty", opsum_out, 9'h0);

    chk("scoreboard_leftover", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
